mem_port_arbiter: RTL and testbench

//  Shares the single-ported unified instruction/data memory of the multicycle CPU

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and arbitration policy for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_DONE
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } arb_owner_t;

    // CPU wins, unless CPU is absent or DMA has waited out the starvation bound.
    // The result is only meaningful when at least one request is present.
    function automatic arb_owner_t arb_pick(input logic cpu_req,
                                            input logic dma_req,
                                            input logic starve_full);
        if (cpu_req && !(dma_req && starve_full)) begin
            return OWN_CPU;
        end
        return OWN_DMA;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the CPU memory path and the DMA/loader.
// One fixed-latency access at a time; CPU has priority, bounded by a starvation count.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_FULL = STV_W'(STARVE_MAX);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, pick;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [STV_W-1:0]  starve_q;
    logic              grant;
    logic              last_beat;

    assign pick      = arb_pick(cpu_req, dma_req, starve_q == STV_FULL);
    assign grant     = (state_q == ARB_IDLE) && (cpu_req || dma_req);
    assign last_beat = (state_q == ARB_ACCESS) && (cnt_q == '0);

    // Address and write data always come from the transaction latched at grant.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // State register; async reset drops strobes and ready in the cycle reset rises.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe/ready decode from the current state and latched owner.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        cpu_ready = 1'b0;
        dma_ready = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (cpu_req || dma_req) begin
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                mem_read  = ~we_q;
                mem_write = we_q;
                if (cnt_q == '0) begin
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
                cpu_ready = (owner_q == OWN_CPU);
                dma_ready = (owner_q == OWN_DMA);
                state_d   = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Latch the granted transaction, run the latency counter, track DMA starvation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q  <= OWN_CPU;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
        end else if (grant) begin
            owner_q <= pick;
            if (pick == OWN_CPU) begin
                we_q    <= cpu_we;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
            end else begin
                we_q    <= dma_we;
                addr_q  <= dma_addr;
                wdata_q <= dma_wdata;
            end
            cnt_q <= CNT_LOAD;
            // Only a CPU grant over a waiting DMA moves the count; anything else clears it.
            if (pick == OWN_CPU && dma_req) begin
                if (starve_q != STV_FULL) begin
                    starve_q <= starve_q + STV_W'(1);
                end
            end else begin
                starve_q <= '0;
            end
        end else if (state_q == ARB_ACCESS && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Capture read data for the owner on the last access edge; the other port is untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else if (last_beat && !we_q) begin
            if (owner_q == OWN_CPU) begin
                cpu_rdata <= mem_rdata;
            end else begin
                dma_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scoreboard of expected accesses,
// a behavioural memory, and directed cycle checks around latency, priority and reset.
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        cpu_ready, dma_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    typedef struct {
        bit          is_dma;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem   [256];
    logic [31:0] mem_model [256];
    int          n_checks = 0;
    int          n_pass   = 0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-ported memory, word indexed.
    always @(posedge clk) if (mem_write) mem_model[mem_addr[9:2]] <= mem_wdata;
    assign mem_rdata = mem_model[mem_addr[9:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit is_dma, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata);
        exp_t e;
        e.is_dma = is_dma;
        e.we     = we;
        e.addr   = addr;
        e.wdata  = wdata;
        e.rdata  = we ? 32'h0 : ref_mem[addr[9:2]];
        if (we) ref_mem[addr[9:2]] = wdata;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input bit is_dma, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(is_dma ? dma_ready : cpu_ready) && n < 20);
        check(tag, {31'b0, (is_dma ? dma_ready : cpu_ready)}, 32'h1);
    endtask

    task automatic do_access(input bit is_dma, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata);
        push_exp(is_dma, we, addr, wdata);
        if (is_dma) begin
            dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        end
        wait_ready(is_dma, is_dma ? "dma_ready_wait" : "cpu_ready_wait");
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick();
    endtask

    // Monitor: strobes must match the head of the scoreboard; ready pops it.
    initial begin
        int          beats = 0;
        logic [31:0] exp_cpu_rd = '0;
        logic [31:0] exp_dma_rd = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                beats      = 0;
                exp_cpu_rd = '0;
                exp_dma_rd = '0;
            end else begin
                if (mem_read || mem_write) begin
                    if (sb.size() == 0) begin
                        check("strobe_unexpected", 32'h1, 32'h0);
                    end else begin
                        check("mem_addr", mem_addr, sb[0].addr);
                        check("mem_write", {31'b0, mem_write}, {31'b0, sb[0].we});
                        check("mem_read", {31'b0, mem_read}, {31'b0, !sb[0].we});
                        if (sb[0].we) check("mem_wdata", mem_wdata, sb[0].wdata);
                    end
                    beats++;
                end
                if (cpu_ready || dma_ready) begin
                    check("single_ready", {31'b0, cpu_ready && dma_ready}, 32'h0);
                    if (sb.size() == 0) begin
                        check("ready_unexpected", 32'h1, 32'h0);
                    end else begin
                        e = sb.pop_front();
                        check("ready_owner", {31'b0, dma_ready}, {31'b0, e.is_dma});
                        check("strobe_beats", beats, MEM_LAT);
                        if (!e.we) begin
                            if (e.is_dma) exp_dma_rd = e.rdata;
                            else          exp_cpu_rd = e.rdata;
                        end
                    end
                    beats = 0;
                    check("cpu_rdata", cpu_rdata, exp_cpu_rd);
                    check("dma_rdata", dma_rdata, exp_dma_rd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        int quiet;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        tick(); tick();

        // Reset state
        check("rst_mem_read",  {31'b0, mem_read},  32'h0);
        check("rst_mem_write", {31'b0, mem_write}, 32'h0);
        check("rst_cpu_ready", {31'b0, cpu_ready}, 32'h0);
        check("rst_dma_ready", {31'b0, dma_ready}, 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_dma_rdata", dma_rdata, 32'h0);
        check("rst_mem_addr",  mem_addr,  32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        tick();

        // Loader fills memory through the DMA port
        do_access(1'b1, 1'b1, 32'h040, 32'hDEADBEEF);
        do_access(1'b1, 1'b1, 32'h200, 32'hC0DE0001);
        do_access(1'b1, 1'b1, 32'h204, 32'hD0A00002);
        do_access(1'b1, 1'b1, 32'h300, 32'hAAAA0000);
        do_access(1'b1, 1'b1, 32'h304, 32'h5555FFFF);

        // DMA write 0x100
        do_access(1'b1, 1'b1, 32'h100, 32'h12345678);
        check("t2_mem_contents", mem_model[32'h100 >> 2], 32'h12345678);

        // CPU read 0x40 with exact cycle timing
        push_exp(1'b0, 1'b0, 32'h040, 32'h0);
        cpu_we = 1'b0; cpu_addr = 32'h040; cpu_req = 1'b1;
        tick();
        check("t1_c1_read", {31'b0, mem_read}, 32'h1);
        tick();
        check("t1_c2_read",  {31'b0, mem_read},  32'h1);
        check("t1_c2_ready", {31'b0, cpu_ready}, 32'h0);
        tick();
        check("t1_c3_ready", {31'b0, cpu_ready}, 32'h1);
        check("t1_c3_read",  {31'b0, mem_read},  32'h0);
        check("t1_rdata",    cpu_rdata, 32'hDEADBEEF);
        cpu_req = 1'b0;
        tick();
        check("t1_c4_ready", {31'b0, cpu_ready}, 32'h0);

        // cpu_req dropped in the first access cycle still completes
        push_exp(1'b0, 1'b0, 32'h100, 32'h0);
        cpu_addr = 32'h100; cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        tick();
        tick();
        check("t5_c3_ready", {31'b0, cpu_ready}, 32'h1);
        check("t5_rdata",    cpu_rdata, 32'h12345678);
        tick();
        check("t5_c4_ready", {31'b0, cpu_ready}, 32'h0);
        tick();
        check("t5_no_regrant", {31'b0, mem_read}, 32'h0);

        // Both requesting continuously: starvation bound forces periodic DMA grants
        s = 0;
        for (int k = 0; k < 10; k++) begin
            if (s == STARVE_MAX) begin
                push_exp(1'b1, 1'b0, 32'h204, 32'h0);
                s = 0;
            end else begin
                push_exp(1'b0, 1'b0, 32'h200, 32'h0);
                s++;
            end
        end
        cpu_we = 1'b0; cpu_addr = 32'h200; dma_we = 1'b0; dma_addr = 32'h204;
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int n = 0; n < 200 && sb.size() != 0; n++) tick();
        check("t3_drained", sb.size(), 0);
        cpu_req = 1'b0; dma_req = 1'b0;
        tick();

        // Reset during the first access cycle abandons the transfer
        push_exp(1'b0, 1'b0, 32'h040, 32'h0);
        cpu_addr = 32'h040; cpu_req = 1'b1;
        tick();
        check("t4_c1_read", {31'b0, mem_read}, 32'h1);
        reset = 1'b1;
        cpu_req = 1'b0;
        sb.delete();
        #1;
        check("t4_async_read",  {31'b0, mem_read},  32'h0);
        check("t4_async_ready", {31'b0, cpu_ready}, 32'h0);
        check("t4_rdata_clear", cpu_rdata, 32'h0);
        tick(); tick();
        reset = 1'b0;
        quiet = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (cpu_ready || dma_ready || mem_read || mem_write) quiet++;
        end
        check("t4_no_activity", quiet, 0);
        do_access(1'b0, 1'b0, 32'h040, 32'h0);
        check("t4_recover_rdata", cpu_rdata, 32'hDEADBEEF);

        // CPU then DMA back-to-back; CPU's read data is held while DMA's updates
        push_exp(1'b0, 1'b0, 32'h300, 32'h0);
        push_exp(1'b1, 1'b0, 32'h304, 32'h0);
        cpu_we = 1'b0; cpu_addr = 32'h300; dma_we = 1'b0; dma_addr = 32'h304;
        cpu_req = 1'b1; dma_req = 1'b1;
        wait_ready(1'b0, "t6_cpu_ready_wait");
        cpu_req = 1'b0;
        wait_ready(1'b1, "t6_dma_ready_wait");
        dma_req = 1'b0;
        check("t6_cpu_rdata", cpu_rdata, 32'hAAAA0000);
        check("t6_dma_rdata", dma_rdata, 32'h5555FFFF);
        tick(); tick(); tick();
        check("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
